// File: rtl/vgademo_pkg.sv
// Shared constants for the VGA demo pipeline and the state encoding of the
// plane reciprocal divider.
package vgademo_pkg;

    localparam int H_DISPLAY         = 640;
    localparam int PLANE_Y_START     = 240;
    localparam int PLANE_Y_SKIPLINES = 8;

    localparam int RECIP_NUMER = 65536;
    localparam int RECIP_Q_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } recip_state_e;

endpackage

// File: rtl/plane_recip_div_if.sv
// Request/result bundle between the scanline controller (master) and the
// reciprocal divider (slave).
interface plane_recip_div_if #(
    parameter int DEN_W = 9,
    parameter int Q_W   = vgademo_pkg::RECIP_Q_W
);
    logic             start;
    logic [DEN_W-1:0] denom;
    logic             busy;
    logic             done;
    logic [Q_W-1:0]   recip;
    logic             sat;

    modport master (output start, denom, input busy, done, recip, sat);
    modport slave  (input start, denom, output busy, done, recip, sat);
endinterface

// File: rtl/plane_recip_div_step.sv
// One combinational restoring-division step: shift in a numerator bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int DEN_W = 9
) (
    input  logic [DEN_W:0]   rem_i,
    input  logic             num_bit_i,
    input  logic [DEN_W-1:0] denom_i,
    output logic [DEN_W:0]   rem_o,
    output logic             q_o
);
    logic [DEN_W+1:0] shifted;
    logic [DEN_W+1:0] trial;

    // rem_i < denom_i always holds, so the shifted value never reaches the sign bit.
    assign shifted = {rem_i, num_bit_i};
    assign trial   = shifted - {2'b00, denom_i};
    assign q_o     = ~trial[DEN_W+1];
    assign rem_o   = q_o ? trial[DEN_W:0] : shifted[DEN_W:0];
endmodule

// File: rtl/plane_recip_div.sv
// Iterative radix-2^RADIX_BITS divider producing floor(NUMER/denom), saturated
// to Q_W bits, once per scanline for the plane step.
module plane_recip_div
    import vgademo_pkg::*;
#(
    parameter int NUM_W      = 17,
    parameter int NUMER      = RECIP_NUMER,
    parameter int DEN_W      = 9,
    parameter int Q_W        = RECIP_Q_W,
    parameter int RADIX_BITS = 2
) (
    input  logic               clk48,
    input  logic               rst,
    plane_recip_div_if.slave   bus
);
    localparam int ITER  = (NUM_W + RADIX_BITS - 1) / RADIX_BITS;
    localparam int PAD_W = ITER * RADIX_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [PAD_W-1:0] NUM_PAD = PAD_W'(NUMER);

    recip_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W:0]   rem_q, rem_d;
    logic [PAD_W-1:0] num_q, num_d;
    logic [PAD_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic             zero_q, zero_d;
    logic [Q_W-1:0]   recip_q, recip_d;
    logic             sat_q, sat_d;
    logic             done_q, done_d;

    logic [DEN_W:0]        rem_chain [RADIX_BITS+1];
    logic [RADIX_BITS-1:0] qbits;
    logic [PAD_W-1:0]      quo_next;
    logic                  ovf;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < RADIX_BITS; i++) begin : g_step
        div_step #(.DEN_W(DEN_W)) u_step (
            .rem_i     (rem_chain[i]),
            .num_bit_i (num_q[PAD_W-1-i]),
            .denom_i   (den_q),
            .rem_o     (rem_chain[i+1]),
            .q_o       (qbits[RADIX_BITS-1-i])
        );
    end

    assign quo_next = {quo_q[PAD_W-RADIX_BITS-1:0], qbits};
    // Bits shifted out of the quotient register are folded in as a sticky overflow guard.
    assign ovf = (|quo_next[PAD_W-1:Q_W]) | (|quo_q[PAD_W-1 -: RADIX_BITS]);

    // NOTE: every *_d gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        num_d   = num_q;
        quo_d   = quo_q;
        den_d   = den_q;
        zero_d  = zero_q;
        recip_d = recip_q;
        sat_d   = sat_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    den_d   = bus.denom;
                    zero_d  = (bus.denom == '0);
                    rem_d   = '0;
                    quo_d   = '0;
                    num_d   = NUM_PAD;
                    cnt_d   = CNT_W'(ITER);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (zero_q) begin
                    recip_d = '1;
                    sat_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    rem_d = rem_chain[RADIX_BITS];
                    quo_d = quo_next;
                    num_d = num_q << RADIX_BITS;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        recip_d = ovf ? '1 : quo_next[Q_W-1:0];
                        sat_d   = ovf;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk48) begin
        // NOTE: the datapath registers are reset too, so a mid-division reset leaves no stale remainder.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            zero_q  <= 1'b0;
            recip_q <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            zero_q  <= zero_d;
            recip_q <= recip_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.recip = recip_q;
    assign bus.sat   = sat_q;
endmodule

// File: tb/tb_plane_recip_div.sv
// Directed and randomised checks of plane_recip_div: results, saturation,
// latency, ignored starts, mid-operation reset and back-to-back requests.
module tb_plane_recip_div;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    plane_recip_div_if bus ();

    plane_recip_div dut (
        .clk48 (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  denom;
        logic [10:0] recip;
        logic        sat;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start in the current cycle and returns in the done cycle.
    task automatic do_div(input logic [8:0] d, output int lat, output logic [10:0] r,
                          output logic s, output int busy_cycles);
        bus.start   = 1'b1;
        bus.denom   = d;
        busy_cycles = 0;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cycles++;
            tick();
            lat++;
        end
        if (bus.busy) busy_cycles++;
        r = bus.recip;
        s = bus.sat;
    endtask

    vec_t        vecs[11];
    int          lat, bcy, seen_done, q_model;
    logic [10:0] r;
    logic        s;
    logic [8:0]  d;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{9'd34,  11'd1927, 1'b0, 10};
        vecs[1]  = '{9'd273, 11'd240,  1'b0, 10};
        vecs[2]  = '{9'd511, 11'd128,  1'b0, 10};
        vecs[3]  = '{9'd1,   11'd2047, 1'b1, 10};
        vecs[4]  = '{9'd0,   11'd2047, 1'b1, 2};
        vecs[5]  = '{9'd100, 11'd655,  1'b0, 10};
        vecs[6]  = '{9'd2,   11'd2047, 1'b1, 10};
        vecs[7]  = '{9'd32,  11'd2047, 1'b1, 10};
        vecs[8]  = '{9'd33,  11'd1985, 1'b0, 10};
        vecs[9]  = '{9'd255, 11'd257,  1'b0, 10};
        vecs[10] = '{9'd3,   11'd2047, 1'b1, 10};

        bus.start = 1'b0;
        bus.denom = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_busy",  32'(bus.busy),  0);
        check("reset_done",  32'(bus.done),  0);
        check("reset_recip", 32'(bus.recip), 0);
        check("reset_sat",   32'(bus.sat),   0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            tick();
            do_div(vecs[i].denom, lat, r, s, bcy);
            check($sformatf("vec%0d_recip d=%0d", i, vecs[i].denom), 32'(r), 32'(vecs[i].recip));
            check($sformatf("vec%0d_sat d=%0d", i, vecs[i].denom), 32'(s), 32'(vecs[i].sat));
            check($sformatf("vec%0d_latency d=%0d", i, vecs[i].denom), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles d=%0d", i, vecs[i].denom), bcy, vecs[i].lat);
        end

        // Start while busy must be ignored.
        tick();
        bus.start = 1'b1;
        bus.denom = 9'd34;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        bus.denom = 9'd100;
        tick();
        bus.start = 1'b0;
        lat = 5;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        check("ignored_start_latency", lat, 10);
        check("ignored_start_recip", 32'(bus.recip), 1927);
        seen_done = 0;
        repeat (20) begin
            tick();
            if (bus.done) seen_done++;
        end
        check("ignored_start_no_second_done", seen_done, 0);
        check("ignored_start_recip_held", 32'(bus.recip), 1927);
        check("ignored_start_idle", 32'(bus.busy), 0);

        // Reset in cycle t+5 abandons the division.
        bus.start = 1'b1;
        bus.denom = 9'd34;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_busy",  32'(bus.busy),  0);
        check("midreset_done",  32'(bus.done),  0);
        check("midreset_recip", 32'(bus.recip), 0);
        check("midreset_sat",   32'(bus.sat),   0);
        seen_done = 0;
        repeat (15) begin
            tick();
            if (bus.done) seen_done++;
        end
        check("midreset_no_done", seen_done, 0);
        do_div(9'd100, lat, r, s, bcy);
        check("after_reset_recip", 32'(r), 655);
        check("after_reset_latency", lat, 10);

        // Start in the done cycle is ignored; start in the next IDLE cycle is accepted.
        tick();
        do_div(9'd273, lat, r, s, bcy);
        check("b2b_first_recip", 32'(r), 240);
        bus.start = 1'b1;
        bus.denom = 9'd100;
        tick();
        bus.start = 1'b0;
        check("fin_start_ignored", 32'(bus.busy), 0);
        do_div(9'd511, lat, r, s, bcy);
        check("b2b_second_recip", 32'(r), 128);
        check("b2b_second_latency", lat, 10);

        for (int k = 0; k < 40; k++) begin
            d = 9'($urandom_range(1, 511));
            q_model = 65536 / int'(d);
            tick();
            do_div(d, lat, r, s, bcy);
            check($sformatf("rand_recip d=%0d", d), 32'(r), (q_model > 2047) ? 2047 : q_model);
            check($sformatf("rand_sat d=%0d", d), 32'(s), (q_model > 2047) ? 1 : 0);
            check($sformatf("rand_latency d=%0d", d), lat, 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
